// File: rtl/logo_sprite_ctrl.sv
// Logo sprite compositor: maps the raster onto a bouncing 352x176 logo, fetches
// palette colours from the logo ROM, applies colour-key transparency, drives RGB.
module logo_sprite_ctrl #(
    parameter int          LOGO_W    = 352,
    parameter int          LOGO_H    = 176,
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          STEP      = 1,
    parameter logic [11:0] KEY_COLOR = 12'h808,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_valid,
    input  logic        frame_start,
    input  logic        move_en,
    output logic [15:0] rom_addr,
    input  logic [11:0] rom_color,
    output logic [11:0] rgb_out,
    output logic        rgb_valid,
    output logic [9:0]  logo_x,
    output logic [9:0]  logo_y,
    output logic [7:0]  bounce_cnt
);

    localparam logic [10:0] LOGO_W11 = 11'(LOGO_W);
    localparam logic [10:0] LOGO_H11 = 11'(LOGO_H);
    localparam logic [15:0] LOGO_W16 = 16'(LOGO_W);
    localparam logic [10:0] X_LIM    = 11'(H_ACTIVE - LOGO_W);
    localparam logic [10:0] Y_LIM    = 11'(V_ACTIVE - LOGO_H);
    localparam logic [10:0] STEP11   = 11'(STEP);
    localparam logic [9:0]  STEP10   = 10'(STEP);
    localparam logic [9:0]  X_INIT   = 10'((H_ACTIVE - LOGO_W) / 2);
    localparam logic [9:0]  Y_INIT   = 10'((V_ACTIVE - LOGO_H) / 2);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_UPD_X = 2'd1,
        ST_UPD_Y = 2'd2
    } state_t;

    state_t      state_r;
    logic [9:0]  logo_x_r;
    logic [9:0]  logo_y_r;
    logic        dir_x_r;
    logic        dir_y_r;
    logic [7:0]  bounce_cnt_r;
    logic [15:0] rom_addr_r;
    logic        s1_in_box_r;
    logic        s1_valid_r;
    logic [11:0] rgb_out_r;
    logic        rgb_valid_r;

    logic [10:0] px_s;
    logic [10:0] py_s;
    logic [10:0] lx_s;
    logic [10:0] ly_s;
    logic [9:0]  dx_s;
    logic [9:0]  dy_s;
    logic        in_box_s;
    logic [15:0] addr_s;
    logic [11:0] x_step_s;
    logic [11:0] y_step_s;

    // One axis move: returns {hit, new_dir (1 = increasing), new_pos}.
    function automatic logic [11:0] step_axis(input logic [9:0] pos,
                                              input logic dir_pos,
                                              input logic [10:0] lim);
        logic [10:0] sum;
        logic [11:0] res;
        sum = {1'b0, pos} + STEP11;
        if (dir_pos) begin
            if (sum >= lim) begin
                res = {1'b1, 1'b0, lim[9:0]};
            end else begin
                res = {1'b0, 1'b1, sum[9:0]};
            end
        end else begin
            if ({1'b0, pos} <= STEP11) begin
                res = {1'b1, 1'b1, 10'd0};
            end else begin
                res = {1'b0, 1'b0, pos - STEP10};
            end
        end
        return res;
    endfunction

    // Saturating reversal counter increment.
    function automatic logic [7:0] bump(input logic [7:0] cnt, input logic hit);
        logic [7:0] res;
        if (hit && (cnt != 8'd255)) begin
            res = cnt + 8'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Stage-1 box test and ROM address, compared at 11 bits to avoid overflow.
    always_comb begin
        px_s     = {1'b0, pix_x};
        py_s     = {1'b0, pix_y};
        lx_s     = {1'b0, logo_x_r};
        ly_s     = {1'b0, logo_y_r};
        dx_s     = pix_x - logo_x_r;
        dy_s     = pix_y - logo_y_r;
        in_box_s = pix_valid
                   && (px_s >= lx_s) && (px_s < (lx_s + LOGO_W11))
                   && (py_s >= ly_s) && (py_s < (ly_s + LOGO_H11));
        addr_s   = (16'(dy_s) * LOGO_W16) + 16'(dx_s);
        x_step_s = step_axis(logo_x_r, dir_x_r, X_LIM);
        y_step_s = step_axis(logo_y_r, dir_y_r, Y_LIM);
    end

    // Two-stage pixel pipeline: address fetch, then key/background compositing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_r  <= 16'd0;
            s1_in_box_r <= 1'b0;
            s1_valid_r  <= 1'b0;
            rgb_out_r   <= 12'd0;
            rgb_valid_r <= 1'b0;
        end else begin
            rom_addr_r  <= in_box_s ? addr_s : 16'd0;
            s1_in_box_r <= in_box_s;
            s1_valid_r  <= pix_valid;
            rgb_valid_r <= s1_valid_r;
            if (!s1_valid_r) begin
                rgb_out_r <= 12'd0;
            end else if (s1_in_box_r && (rom_color != KEY_COLOR)) begin
                rgb_out_r <= rom_color;
            end else begin
                rgb_out_r <= BG_COLOR;
            end
        end
    end

    // Position FSM: one X step then one Y step per enabled frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_WAIT;
            logo_x_r     <= X_INIT;
            logo_y_r     <= Y_INIT;
            dir_x_r      <= 1'b1;
            dir_y_r      <= 1'b1;
            bounce_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (frame_start && move_en) begin
                        state_r <= ST_UPD_X;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_UPD_X: begin
                    logo_x_r     <= x_step_s[9:0];
                    dir_x_r      <= x_step_s[10];
                    bounce_cnt_r <= bump(bounce_cnt_r, x_step_s[11]);
                    state_r      <= ST_UPD_Y;
                end
                ST_UPD_Y: begin
                    logo_y_r     <= y_step_s[9:0];
                    dir_y_r      <= y_step_s[10];
                    bounce_cnt_r <= bump(bounce_cnt_r, y_step_s[11]);
                    state_r      <= ST_WAIT;
                end
                default: begin
                    state_r <= ST_WAIT;
                end
            endcase
        end
    end

    assign rom_addr   = rom_addr_r;
    assign rgb_out    = rgb_out_r;
    assign rgb_valid  = rgb_valid_r;
    assign logo_x     = logo_x_r;
    assign logo_y     = logo_y_r;
    assign bounce_cnt = bounce_cnt_r;

endmodule

// File: tb/tb_logo_sprite_ctrl.sv
// Directed bench for logo_sprite_ctrl: pipeline, transparency, bounce motion, resets.
module tb_logo_sprite_ctrl;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic        frame_start;
    logic        move_en;
    logic [15:0] rom_addr;
    logic [11:0] rom_color;
    logic [11:0] rgb_out;
    logic        rgb_valid;
    logic [9:0]  logo_x;
    logic [9:0]  logo_y;
    logic [7:0]  bounce_cnt;
    logic        rom_key;

    int vectors;
    int miscompares;

    logo_sprite_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .frame_start(frame_start), .move_en(move_en),
        .rom_addr(rom_addr), .rom_color(rom_color), .rgb_out(rgb_out),
        .rgb_valid(rgb_valid), .logo_x(logo_x), .logo_y(logo_y),
        .bounce_cnt(bounce_cnt)
    );

    // ROM stand-in: colour derived from the address, or the key colour on demand.
    assign rom_color = rom_key ? 12'h808 : (rom_addr[11:0] ^ 12'h940);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_pix(input logic v, input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        pix_valid = v;
        pix_x = x;
        pix_y = y;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({rom_addr, rgb_out, rgb_valid} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset_out addr=%0d rgb=%h v=%b expected 0", rom_addr, rgb_out, rgb_valid);
        end
        vectors++;
        if ({logo_x, logo_y, bounce_cnt} !== {10'd144, 10'd152, 8'd0}) begin
            miscompares++;
            $display("FAIL reset_pos got %0d,%0d,%0d expected 144,152,0", logo_x, logo_y, bounce_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if ({logo_x, logo_y, bounce_cnt, rgb_valid, rom_addr} !== {10'd144, 10'd152, 8'd0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_hold got %0d,%0d,%0d v=%b a=%0d expected 144,152,0,0,0",
                     logo_x, logo_y, bounce_cnt, rgb_valid, rom_addr);
        end
    endtask

    task automatic check_pixel(input string name, input logic v, input logic [9:0] x,
                               input logic [9:0] y, input logic [15:0] exp_addr,
                               input logic [11:0] exp_rgb, input logic exp_v);
        drive_pix(v, x, y);
        drive_pix(1'b0, 10'd0, 10'd0);
        vectors++;
        if (rom_addr !== exp_addr) begin
            miscompares++;
            $display("FAIL %s_addr got %0d expected %0d", name, rom_addr, exp_addr);
        end
        @(negedge clk);
        vectors++;
        if ({rgb_out, rgb_valid} !== {exp_rgb, exp_v}) begin
            miscompares++;
            $display("FAIL %s_rgb got %h/%b expected %h/%b", name, rgb_out, rgb_valid, exp_rgb, exp_v);
        end
    endtask

    task automatic test_corners();
        check_pixel("top_left", 1'b1, 10'd144, 10'd152, 16'd0, 12'h940, 1'b1);
        check_pixel("bot_right", 1'b1, 10'd495, 10'd327, 16'd61951, 12'h8bf, 1'b1);
    endtask

    task automatic test_transparency();
        check_pixel("left_out", 1'b1, 10'd143, 10'd152, 16'd0, 12'h000, 1'b1);
        check_pixel("right_out", 1'b1, 10'd496, 10'd200, 16'd0, 12'h000, 1'b1);
        check_pixel("below_out", 1'b1, 10'd300, 10'd328, 16'd0, 12'h000, 1'b1);
        rom_key = 1'b1;
        check_pixel("key", 1'b1, 10'd200, 10'd160, 16'd2872, 12'h000, 1'b1);
        rom_key = 1'b0;
        check_pixel("blank", 1'b0, 10'd200, 10'd160, 16'd0, 12'h000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_rgb [4];
        exp_rgb[0] = 12'h940;
        exp_rgb[1] = 12'h941;
        exp_rgb[2] = 12'h942;
        exp_rgb[3] = 12'h943;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                vectors++;
                if (rom_addr !== 16'(i - 1)) begin
                    miscompares++;
                    $display("FAIL stream_addr[%0d] got %0d expected %0d", i - 1, rom_addr, i - 1);
                end
            end
            if (i >= 2) begin
                vectors++;
                if ({rgb_out, rgb_valid} !== {exp_rgb[i - 2], 1'b1}) begin
                    miscompares++;
                    $display("FAIL stream_rgb[%0d] got %h/%b expected %h/1", i - 2, rgb_out, rgb_valid, exp_rgb[i - 2]);
                end
            end
            pix_valid = (i < 4);
            pix_x = 10'(144 + i);
            pix_y = 10'd152;
        end
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_pos(input string name, input logic [9:0] ex, input logic [9:0] ey,
                             input logic [7:0] eb);
        vectors++;
        if ({logo_x, logo_y, bounce_cnt} !== {ex, ey, eb}) begin
            miscompares++;
            $display("FAIL %s got x=%0d y=%0d b=%0d expected x=%0d y=%0d b=%0d",
                     name, logo_x, logo_y, bounce_cnt, ex, ey, eb);
        end
    endtask

    task automatic test_freeze();
        move_en = 1'b0;
        pulse_frame();
        check_pos("freeze", 10'd144, 10'd152, 8'd0);
        move_en = 1'b1;
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 144; i++) pulse_frame();
        check_pos("bounce_x_edge", 10'd288, 10'd296, 8'd1);
        pulse_frame();
        check_pos("bounce_x_back", 10'd287, 10'd297, 8'd1);
        for (int i = 0; i < 7; i++) pulse_frame();
        check_pos("bounce_y_edge", 10'd280, 10'd304, 8'd2);
        pulse_frame();
        check_pos("bounce_y_back", 10'd279, 10'd303, 8'd2);
    endtask

    task automatic test_ignored();
        @(negedge clk);
        frame_start = 1'b1;
        repeat (2) @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
        check_pos("ignored_pulse", 10'd278, 10'd302, 8'd2);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        move_en = 1'b0;
        repeat (3) @(negedge clk);
        check_pos("move_en_drop", 10'd277, 10'd301, 8'd2);
        move_en = 1'b1;
    endtask

    task automatic test_live_position();
        check_pixel("moved_corner", 1'b1, 10'd277, 10'd301, 16'd0, 12'h940, 1'b1);
        check_pixel("moved_out", 1'b1, 10'd276, 10'd301, 16'd0, 12'h000, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_pos("reset_mid", 10'd144, 10'd152, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_frame();
        check_pos("after_reset", 10'd145, 10'd153, 8'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b1;
        pix_x = 10'd0;
        pix_y = 10'd0;
        pix_valid = 1'b0;
        frame_start = 1'b0;
        move_en = 1'b0;
        rom_key = 1'b0;
        test_reset();
        test_corners();
        test_transparency();
        test_back_to_back();
        test_freeze();
        test_bounce();
        test_ignored();
        test_live_position();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
